// File: rtl/dsp_pkg.sv
// Shared IIR datapath definitions: common sample width and a constant clog2.
package dsp_pkg;

  localparam int SAMPLE_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/delay_channel.sv
// One channel's MAX_DEPTH x N shift chain; taps[k-1] holds the sample from k shifts ago.
module delay_channel
  import dsp_pkg::*;
#(
  parameter int N         = SAMPLE_W,
  parameter int MAX_DEPTH = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           clr,
  input  logic                           shift,
  input  logic [N-1:0]                   din,
  output logic [MAX_DEPTH-1:0][N-1:0]    taps
);

  logic [MAX_DEPTH-1:0][N-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (shift) begin
      mem_d[0] = din;
      for (int k = 1; k < MAX_DEPTH; k++) mem_d[k] = mem_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign taps = mem_q;

endmodule

// File: rtl/tdm_delay_line.sv
// Multi-channel TDM sample delay line with per-channel runtime depth.
// Optional DELAY_TAPS_EN adds a registered taps_out port with the post-shift history of dout_ch.
module tdm_delay_line
  import dsp_pkg::*;
#(
  parameter int  N         = SAMPLE_W,
  parameter int  CHANNELS  = 2,
  parameter int  MAX_DEPTH = 8,
  localparam int CH_W      = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1,
  localparam int D_W       = clog2(MAX_DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               din_valid,
  input  logic [N-1:0]       din,
  input  logic [D_W-1:0]     depth,
  input  logic               flush,
  output logic               dout_valid,
  output logic [N-1:0]       dout,
  output logic [CH_W-1:0]    dout_ch
`ifdef DELAY_TAPS_EN
  ,
  output logic [N*MAX_DEPTH-1:0] taps_out
`endif
);

  logic [CHANNELS-1:0][MAX_DEPTH-1:0][N-1:0] mem;
  logic [CHANNELS-1:0]          shift_en;
  logic [MAX_DEPTH-1:0][N-1:0]  row;
  logic [N-1:0]                 delayed;
  logic [D_W-1:0]               d_eff;
  logic                         accept;

  logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
  logic            dout_valid_q, dout_valid_d;
  logic [N-1:0]    dout_q, dout_d;
  logic [CH_W-1:0] dout_ch_q, dout_ch_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    delay_channel #(.N(N), .MAX_DEPTH(MAX_DEPTH)) u_ch (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (flush),
      .shift (shift_en[c]),
      .din   (din),
      .taps  (mem[c])
    );
  end

  always_comb begin
    accept = din_valid & ~flush;
    d_eff  = (depth > D_W'(MAX_DEPTH)) ? D_W'(MAX_DEPTH) : depth;

    row = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      shift_en[c] = accept && (ch_cnt_q == CH_W'(c));
      if (ch_cnt_q == CH_W'(c)) row = mem[c];
    end

    // Read is taken before the shift lands, so mem[c][d] is d samples back.
    delayed = din;
    for (int k = 1; k <= MAX_DEPTH; k++)
      if (d_eff == D_W'(k)) delayed = row[k-1];

    ch_cnt_d     = ch_cnt_q;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    if (flush) begin
      ch_cnt_d = '0;
    end else if (din_valid) begin
      ch_cnt_d     = (ch_cnt_q == CH_W'(CHANNELS - 1)) ? '0 : ch_cnt_q + 1'b1;
      dout_valid_d = 1'b1;
      dout_d       = delayed;
      dout_ch_d    = ch_cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ch_cnt_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
    end else begin
      ch_cnt_q     <= ch_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;

`ifdef DELAY_TAPS_EN
  logic [MAX_DEPTH-1:0][N-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (flush) begin
      taps_d = '0;
    end else if (accept) begin
      taps_d[0] = din;
      for (int k = 1; k < MAX_DEPTH; k++) taps_d[k] = row[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) taps_q <= '0;
    else      taps_q <= taps_d;
  end

  assign taps_out = taps_q;
`endif

endmodule

// File: tb/tb_tdm_delay_line.sv
// Directed + randomized bench for tdm_delay_line against a queue-style history model.
module tb_tdm_delay_line;

  localparam int N = 8, CH = 2, MD = 8, DW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          din_valid = 1'b0;
  logic [N-1:0]  din = '0;
  logic [DW-1:0] depth = '0;
  logic          flush = 1'b0;
  logic          dout_valid;
  logic [N-1:0]  dout;
  logic [0:0]    dout_ch;
`ifdef DELAY_TAPS_EN
  logic [N*MD-1:0] taps_out;
`endif

  tdm_delay_line #(.N(N), .CHANNELS(CH), .MAX_DEPTH(MD)) dut (
    .CLK(CLK), .RST(RST), .din_valid(din_valid), .din(din), .depth(depth),
    .flush(flush), .dout_valid(dout_valid), .dout(dout), .dout_ch(dout_ch)
`ifdef DELAY_TAPS_EN
    , .taps_out(taps_out)
`endif
  );

  always #5 CLK = ~CLK;

  // Model: hist[c][j] = channel c sample accepted j+1 samples ago.
  logic [N-1:0]    hist [CH][MD];
  int              m_ch;
  logic            exp_v;
  logic [N-1:0]    exp_d;
  logic [0:0]      exp_ch;
  logic [N*MD-1:0] exp_taps;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) for (int j = 0; j < MD; j++) hist[c][j] = '0;
    m_ch = 0; exp_v = 0; exp_taps = '0;
  endtask

  task automatic step(input logic v, input logic [N-1:0] x, input logic [DW-1:0] dep,
                      input logic fl);
    int d;
    @(negedge CLK);
    din_valid = v; din = x; depth = dep; flush = fl;
    if (fl) begin
      for (int c = 0; c < CH; c++) for (int j = 0; j < MD; j++) hist[c][j] = '0;
      m_ch = 0; exp_v = 0; exp_taps = '0;
    end else if (v) begin
      d = (int'(dep) > MD) ? MD : int'(dep);
      exp_d  = (d == 0) ? x : hist[m_ch][d-1];
      exp_ch = 1'(m_ch);
      exp_v  = 1;
      for (int j = MD - 1; j > 0; j--) hist[m_ch][j] = hist[m_ch][j-1];
      hist[m_ch][0] = x;
      for (int j = 0; j < MD; j++) exp_taps[j*N +: N] = hist[m_ch][j];
      m_ch = (m_ch + 1) % CH;
    end else begin
      exp_v = 0;
    end
    @(posedge CLK); #1;
    din_valid = 0; flush = 0;
    chk("dout_valid", 64'(dout_valid), 64'(exp_v));
    chk("dout", 64'(dout), 64'(exp_d));
    chk("dout_ch", 64'(dout_ch), 64'(exp_ch));
`ifdef DELAY_TAPS_EN
    chk("taps_out", taps_out, exp_taps);
`endif
  endtask

  task automatic interleaved(input bit gaps);
    step(0, 8'h00, 4'd3, 1);
    for (int i = 0; i < 5; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step(0, 8'(i), 4'd3, 0);
      step(1, 8'(i + 1), 4'd3, 0);
      chk("il_ch0", {56'd0, dout_ch, dout}, {56'd0, 1'b0, (i < 3) ? 8'd0 : 8'(i - 2)});
      if (gaps) repeat ($urandom_range(0, 3)) step(0, 8'(i), 4'd3, 0);
      step(1, 8'(101 + i), 4'd3, 0);
      chk("il_ch1", {56'd0, dout_ch, dout}, {56'd0, 1'b1, (i < 3) ? 8'd0 : 8'(98 + i)});
    end
  endtask

  initial begin
    model_clear();
    exp_d = '0; exp_ch = '0;
    // Reset held: outputs stay zero even with din_valid toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); din_valid = ~din_valid; din = 8'(i + 7);
      @(posedge CLK); #1;
      chk("rst_valid", 64'(dout_valid), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_ch", 64'(dout_ch), 64'd0);
    end
    @(negedge CLK); din_valid = 0; RST = 1;

    step(1, 8'h11, 4'd1, 0);
    chk("first_ch", 64'(dout_ch), 64'd0);

    interleaved(0);
    interleaved(1);

    // depth 0 is a pass-through
    step(1, 8'h5A, 4'd0, 0);
    chk("depth0", 64'(dout), 64'h5A);

    // depth 12 clamps to 8: ch0 sample 1 surfaces on ch0's 9th output
    step(0, 8'h00, 4'd0, 1);
    for (int i = 1; i <= 9; i++) begin
      step(1, 8'(i), 4'd12, 0);
      if (i == 8) chk("clamp_8th", 64'(dout), 64'd0);
      if (i == 9) chk("clamp_9th", 64'(dout), 64'd1);
`ifdef DELAY_TAPS_EN
      if (i == 8) chk("taps_1to8", taps_out, 64'h0102030405060708);
`endif
      step(1, 8'(200 + i), 4'd12, 0);
    end

    // Flush with valid mid-stream: sample dropped, restart on ch0 with zero history
    step(1, 8'h33, 4'd2, 0);
    step(1, 8'h44, 4'd2, 1);
    chk("flush_novalid", 64'(dout_valid), 64'd0);
    step(1, 8'h55, 4'd2, 0);
    chk("flush_ch0", 64'(dout_ch), 64'd0);
    chk("flush_zero", 64'(dout), 64'd0);

    // Async reset mid-stream discards history
    step(1, 8'h66, 4'd1, 0);
    @(negedge CLK); RST = 0; #1;
    model_clear(); exp_d = '0; exp_ch = '0;
    chk("arst_valid", 64'(dout_valid), 64'd0);
    chk("arst_dout", 64'(dout), 64'd0);
    @(negedge CLK); RST = 1;
    step(1, 8'h77, 4'd1, 0);
    chk("arst_ch0", 64'(dout_ch), 64'd0);
    chk("arst_hist", 64'(dout), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 12)),
           1'($urandom_range(0, 39) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_delay_line.md
# tdm_delay_line

Multi-channel, runtime-programmable sample delay line for the IIR filter datapath. Time-interleaved (TDM) channels share one input bus. Each accepted sample is delayed by `depth` samples of its own channel, so per-channel delay state advances only when that channel's sample arrives. It generalises the fixed N-bit register chain into a gated, per-channel, variable-depth store that feeds the feedback/feedforward terms of multichannel IIR sections.

## Interface
- N, 8, sample width in bits
- CHANNELS, 2, number of interleaved channels (≥1)
- MAX_DEPTH, 8, maximum delay in samples per channel (≥1)
- CH_W, derived, channel index width, max(1, clog2(CHANNELS))
- D_W, derived, depth field width, clog2(MAX_DEPTH+1)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-low
- din_valid  input  1  din carries a sample this cycle
- din  input  N  sample for channel `ch_cnt`
- depth  input  D_W  requested delay in samples; sampled on each accepted input
- flush  input  1  synchronous clear of all storage and the channel counter
- dout_valid  output  1  dout/dout_ch valid
- dout  output  N  delayed sample
- dout_ch  output  CH_W  channel index of dout
- taps_out  output  N*MAX_DEPTH  present only with DELAY_TAPS_EN (see Configuration)

## Operation
- Storage: mem[c][k], c = 0..CHANNELS-1, k = 1..MAX_DEPTH. mem[c][k] holds the channel-c sample accepted k samples ago on that channel.
- Channel counter `ch_cnt` runs 0..CHANNELS-1 and advances by one per accepted sample. It wraps from CHANNELS-1 to 0. With CHANNELS=1 it stays at 0.
- Accept = din_valid & ~flush. On accept for channel c:
  - mem[c][1] ← din
  - mem[c][k] ← mem[c][k-1] for k ≥ 2
  - other channels are untouched.
- Effective depth: d = min(depth, MAX_DEPTH). Out-of-range requests are clamped, never wrapped.
- Output on accept:
  - dout ← din when d = 0
  - otherwise dout ← mem[c][d], the value read before the shift.
  - dout_ch ← c
- A channel that has not yet received d samples outputs 0, because storage is zero after reset and after flush.
- A depth change takes effect at the next accepted sample. Storage is not cleared, so that output immediately reflects history at the new depth.
- Flush: all mem ← 0, ch_cnt ← 0, dout_valid ← 0. Flush has priority over a simultaneous din_valid, and that sample is dropped.
- No backpressure: the block always accepts din_valid.

## Timing
- Latency is 1 cycle from accepted din to dout_valid/dout/dout_ch.
- dout_valid is a one-cycle pulse per accepted sample. Back-to-back valids give back-to-back outputs at full rate.
- dout and dout_ch hold their last value while dout_valid = 0.
- Reset (asynchronous assert, synchronous-safe release):
  - dout_valid = 0, dout = 0, dout_ch = 0, ch_cnt = 0, all mem = 0, taps_out = 0.
- Reset asserted mid-stream discards all history. The first accepted sample after release is channel 0.
- Gaps in din_valid do not advance ch_cnt or any storage.

## Configuration
- DELAY_TAPS_EN defined:
  - taps_out is a port, registered with dout on each accepted sample.
  - Slice k-1 (bits N*k-1 : N*(k-1)) carries mem[c][k] after the shift, for k = 1..MAX_DEPTH, of channel c = dout_ch.
  - Slice 0 therefore equals din.
  - Held when dout_valid = 0; cleared by reset and flush.
- DELAY_TAPS_EN undefined: the taps_out port and its registers are absent. All other behaviour is identical.

## Structure
- A shared package `dsp_pkg` holds:
  - the clog2 constant function used for CH_W and D_W
  - the common sample-width default N = 8, shared with the rest of the IIR datapath.
- Sub-module `delay_channel`: one channel's MAX_DEPTH × N shift chain with shift enable and synchronous clear.
  - It is instantiated CHANNELS times in a generate loop.
  - The top level holds ch_cnt, the depth clamp, the output mux and the output registers.

## Test plan
All scenarios use CHANNELS=2, MAX_DEPTH=8, N=8 unless stated.

- **Reset:** hold RST=0 and toggle din_valid → dout_valid=0, dout=0, dout_ch=0. After release, the first accepted sample yields dout_ch=0.
- **Interleaved delay:** depth=3; continuous valid with ch0 = 1,2,3,4,5 interleaved with ch1 = 101..105 → ch0 outputs 0,0,0,1,2 and ch1 outputs 0,0,0,101,102, each 1 cycle after input, with matching dout_ch.
- **Boundary depths:**
  - depth=0 with din=0x5A → next cycle dout=0x5A.
  - depth=12 → behaves as depth=8: ch0 sample 1 emerges on ch0's 9th output.
- **Idle gaps:** insert random idle cycles between valids in the interleaved-delay scenario → identical output sequence, and no dout_valid during gaps.
- **Flush:** assert flush together with din_valid mid-stream → no dout_valid that cycle, the sample is dropped, the next sample is tagged ch0, and the delayed outputs restart at 0.
- **Taps (DELAY_TAPS_EN):** ch0 fed 1..8 → after the 8th accept, taps_out slices 0..7 = 8,7,6,5,4,3,2,1. Without the macro, the same bench compiles with taps checks disabled.
